// File: rtl/mult_pkg.sv
// Shared types for the shift-and-add multiplier: datapath strobe bundle,
// controller state encoding and the default operand width.
package mult_pkg;

   localparam int MULT_N_DEFAULT = 8;

   typedef struct packed {
      logic load_A;
      logic load_B;
      logic load_add;
      logic shift_HQ_LQ;
      logic add_sub;
   } mult_control_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      CHECK = 3'd2,
      ADD   = 3'd3,
      SHIFT = 3'd4,
      DONE  = 3'd5
   } mult_state_t;

   // Moore strobe decode; anything not listed (including illegal codes) is all-zero.
   function automatic mult_control_t decode_strobes(input mult_state_t s);
      mult_control_t c;
      c = '0;
      case (s)
         LOAD: begin
            c.load_A = 1'b1;
            c.load_B = 1'b1;
         end
         ADD:     c.load_add    = 1'b1;
         SHIFT:   c.shift_HQ_LQ = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// Rising-edge detector: one history register and an AND gate.
module edge_detect_rise (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic pulse
);

   logic in_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_q <= 1'b0;
      end else begin
         in_q <= in;
      end
   end

   assign pulse = in & ~in_q;

endmodule

// File: rtl/mult_control_fsm.sv
// Sequencing controller for the shift-and-add multiplier: LOAD, then N rounds
// of CHECK/(ADD)/SHIFT, then a one-cycle DONE.
module mult_control_fsm
   import mult_pkg::*;
#(
   parameter int N = MULT_N_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          Q_LSB,
   output mult_control_t mult_control,
   output logic          busy,
   output logic          done,
   output logic          result_valid
);

   localparam int CNT_W = (N > 2) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N - 1);

   logic             start_rise;
   mult_state_t      state_reg;
   mult_state_t      state_next;
   logic [CNT_W-1:0] counter_reg;
   logic [CNT_W-1:0] counter_next;
   logic             result_valid_next;

   edge_detect_rise u_start_edge (
      .clk   (clk),
      .rst   (rst),
      .in    (start),
      .pulse (start_rise)
   );

   always_comb begin
      state_next        = IDLE;
      counter_next      = counter_reg;
      result_valid_next = result_valid;
      case (state_reg)
         IDLE: begin
            if (start_rise) begin
               state_next        = LOAD;
               result_valid_next = 1'b0;
            end
         end
         LOAD: begin
            counter_next = '0;
            state_next   = CHECK;
         end
         CHECK: state_next = Q_LSB ? ADD : SHIFT;
         ADD:   state_next = SHIFT;
         SHIFT: begin
            // Exit on the last iteration instead of incrementing, so the counter never wraps.
            if (counter_reg == LAST_ITER) begin
               state_next        = DONE;
               result_valid_next = 1'b1;
            end else begin
               counter_next = counter_reg + 1'b1;
               state_next   = CHECK;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         counter_reg  <= '0;
         mult_control <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         state_reg    <= state_next;
         counter_reg  <= counter_next;
         mult_control <= decode_strobes(state_next);
         busy         <= (state_next != IDLE);
         done         <= (state_next == DONE);
         result_valid <= result_valid_next;
      end
   end

endmodule

// File: tb/tb_mult_control_fsm.sv
// Bench for mult_control_fsm: a behavioural shift-and-add datapath closes the
// Q_LSB loop; expectations come from popcount(B) and A*B.
module tb_mult_control_fsm;
   import mult_pkg::*;

   localparam int N = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          Q_LSB;
   mult_control_t mult_control;
   logic          busy;
   logic          done;
   logic          result_valid;

   mult_control_fsm #(.N(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .Q_LSB        (Q_LSB),
      .mult_control (mult_control),
      .busy         (busy),
      .done         (done),
      .result_valid (result_valid)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // behavioural datapath
   logic [7:0] a_in, b_in;
   logic [7:0] dp_a, dp_h, dp_q;
   logic       dp_c;

   // per-run monitor
   int         busy_cnt, add_cnt, shift_cnt, done_cnt, overlap_cnt, addsub_cnt;
   int         done_idx, samp_idx;
   logic [7:0] add_mask;
   logic [15:0] prod_at_done;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      int          exp_busy;
      int          exp_adds;
      logic [15:0] exp_y;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      busy_cnt = 0; add_cnt = 0; shift_cnt = 0; done_cnt = 0;
      overlap_cnt = 0; addsub_cnt = 0; done_idx = -1; samp_idx = 0;
      add_mask = '0; prod_at_done = '0;
   endtask

   function automatic int popcount8(input logic [7:0] v);
      int n = 0;
      for (int i = 0; i < 8; i++) n += int'(v[i]);
      return n;
   endfunction

   // Sample the DUT mid-cycle, then let the datapath act on this cycle's strobes.
   task automatic cycle();
      int active;
      @(negedge clk);
      active = int'(mult_control.load_A | mult_control.load_B)
             + int'(mult_control.load_add) + int'(mult_control.shift_HQ_LQ);
      if (active > 1 || mult_control.load_A != mult_control.load_B) overlap_cnt++;
      if (mult_control.add_sub && !mult_control.load_add) addsub_cnt++;
      if (busy) busy_cnt++;
      if (mult_control.load_add) begin
         add_cnt++;
         if (shift_cnt < 8) add_mask[shift_cnt] = 1'b1;
      end
      if (mult_control.shift_HQ_LQ) shift_cnt++;
      if (done) begin
         done_cnt++;
         done_idx     = samp_idx;
         prod_at_done = {dp_h, dp_q};
      end
      if (rst) begin
         dp_a = '0; dp_h = '0; dp_q = '0; dp_c = 1'b0;
      end else begin
         if (mult_control.load_A) dp_a = a_in;
         if (mult_control.load_B) begin
            dp_q = b_in; dp_h = '0; dp_c = 1'b0;
         end
         if (mult_control.load_add) {dp_c, dp_h} = {1'b0, dp_h} + {1'b0, dp_a};
         if (mult_control.shift_HQ_LQ) begin
            {dp_h, dp_q} = {dp_c, dp_h, dp_q[7:1]};
            dp_c = 1'b0;
         end
      end
      Q_LSB = dp_q[0];
      samp_idx++;
   endtask

   task automatic run_and_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                                input int exp_busy, input int exp_adds, input logic [15:0] exp_y);
      a_in = a;
      b_in = b;
      clear_mon();
      start = 1'b1;
      cycle();
      start = 1'b0;
      check({tag, "_load"}, 32'({mult_control.load_A, mult_control.load_B, busy, result_valid}),
            32'(4'b1110));
      for (int i = 0; i < 60 && done_cnt == 0; i++) cycle();
      cycle();
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check({tag, "_busy"}, 32'(busy_cnt), 32'(exp_busy));
      check({tag, "_done_idx"}, 32'(done_idx), 32'(exp_busy - 1));
      check({tag, "_adds"}, 32'(add_cnt), 32'(exp_adds));
      check({tag, "_shifts"}, 32'(shift_cnt), 32'(N));
      check({tag, "_add_mask"}, 32'(add_mask), 32'(b));
      check({tag, "_overlap"}, 32'(overlap_cnt + addsub_cnt), 32'd0);
      check({tag, "_product"}, 32'(prod_at_done), 32'(exp_y));
      check({tag, "_after"}, 32'({busy, done, result_valid}), 32'(3'b001));
      $display("run %s A=%0d B=%0d busy=%0d adds=%0d Y=%0d", tag, a, b, busy_cnt, add_cnt,
               prod_at_done);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] ra, rb;

      vecs[0] = '{a: 8'd77,  b: 8'h00, exp_busy: 18, exp_adds: 0, exp_y: 16'd0};
      vecs[1] = '{a: 8'd3,   b: 8'h05, exp_busy: 20, exp_adds: 2, exp_y: 16'd15};
      vecs[2] = '{a: 8'd90,  b: 8'hFF, exp_busy: 26, exp_adds: 8, exp_y: 16'd22950};
      vecs[3] = '{a: 8'd12,  b: 8'd10, exp_busy: 20, exp_adds: 2, exp_y: 16'd120};
      vecs[4] = '{a: 8'd255, b: 8'd255, exp_busy: 26, exp_adds: 8, exp_y: 16'd65025};
      vecs[5] = '{a: 8'd200, b: 8'h80, exp_busy: 19, exp_adds: 1, exp_y: 16'd25600};

      rst = 1'b1; start = 1'b0; Q_LSB = 1'b0; a_in = '0; b_in = '0;
      dp_a = '0; dp_h = '0; dp_q = '0; dp_c = 1'b0;
      clear_mon();
      repeat (3) cycle();
      check("reset_state", 32'({mult_control, busy, done, result_valid}), 32'd0);
      rst = 1'b0;
      repeat (3) cycle();
      check("idle_quiet", 32'(busy_cnt + add_cnt + shift_cnt + done_cnt), 32'd0);

      for (int v = 0; v < 6; v++)
         run_and_check($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].exp_busy,
                       vecs[v].exp_adds, vecs[v].exp_y);

      for (int r = 0; r < 12; r++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         run_and_check($sformatf("rnd%0d", r), ra, rb, 2 + 2 * N + popcount8(rb),
                       popcount8(rb), 16'(int'(ra) * int'(rb)));
      end

      // Reset during ADD of a running multiply.
      a_in = 8'd7; b_in = 8'h05;
      clear_mon();
      start = 1'b1;
      cycle();
      start = 1'b0;
      for (int i = 0; i < 30 && !mult_control.load_add; i++) cycle();
      check("rst_found_add", 32'(mult_control.load_add), 32'd1);
      rst = 1'b1;
      #1;
      check("rst_midop_outputs", 32'({mult_control, busy, done, result_valid}), 32'd0);
      cycle();
      cycle();
      rst = 1'b0;
      clear_mon();
      repeat (10) cycle();
      check("rst_midop_quiet", 32'(busy_cnt + add_cnt + shift_cnt + done_cnt), 32'd0);
      $display("run rst_midop busy_after=%0d", busy_cnt);

      // Start held for 40 cycles: one multiplication only.
      a_in = 8'd3; b_in = 8'h81;
      clear_mon();
      start = 1'b1;
      repeat (40) cycle();
      start = 1'b0;
      repeat (20) cycle();
      check("hold_done_cnt", 32'(done_cnt), 32'd1);
      check("hold_busy", 32'(busy_cnt), 32'd20);
      check("hold_product", 32'(prod_at_done), 32'd387);
      $display("run hold40 done=%0d busy=%0d", done_cnt, busy_cnt);

      // Second rising edge while busy is ignored.
      a_in = 8'd9; b_in = 8'h03;
      clear_mon();
      start = 1'b1;
      cycle();
      start = 1'b0;
      repeat (3) cycle();
      start = 1'b1;
      cycle();
      start = 1'b0;
      repeat (40) cycle();
      check("busy_edge_done_cnt", 32'(done_cnt), 32'd1);
      check("busy_edge_busy", 32'(busy_cnt), 32'd20);
      check("busy_edge_rv_held", 32'(result_valid), 32'd1);
      $display("run busy_edge done=%0d busy=%0d", done_cnt, busy_cnt);

      // New edge after DONE relaunches and clears result_valid in LOAD.
      run_and_check("relaunch", 8'd12, 8'd10, 20, 2, 16'd120);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_control_fsm.md
Name: mult_control_fsm

Overview:
Sequencing controller for the 8-bit shift-and-add multiplier datapath. It sits directly upstream of the multiplier and drives its mult_control bus.
- Waits for a start request from the operand-entry stage.
- Loads the operands A/B.
- Iterates N times: samples Q_LSB, conditionally adds, then shifts.
- Signals completion so the binary-to-BCD and display stages can show the product.

Parameters:
N, 8, operand width in bits; iteration count; must be >= 2.

Ports:
clk  input  1  system clock; single clock domain.
rst  input  1  asynchronous, active-high reset.
start  input  1  multiply request (level, from operand stage). Its rising edge launches one multiplication.
Q_LSB  input  1  LSB of the datapath's Q (multiplier) register, sampled in CHECK.
mult_control  output  mult_control_t  datapath control strobes: load_A, load_B, load_add, shift_HQ_LQ, add_sub.
busy  output  1  high from LOAD through DONE inclusive.
done  output  1  one-cycle pulse in the DONE state.
result_valid  output  1  set in DONE; held until the next accepted start or reset.

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0, start_q=0, every mult_control field=0, busy=0, done=0, result_valid=0. Applies immediately, including mid-operation; the partial product is abandoned.
- Start detection: start_q registers start each cycle. Accept when start=1 and start_q=0 while in IDLE. A level held high never retriggers. Edges outside IDLE are ignored, with no queueing.
- Output style: Moore. mult_control is decoded from registered state only; all strobes are 0 except where listed below.
- State machine and strobes:
  - IDLE: all strobes 0. On an accepted edge, go to LOAD and clear result_valid.
  - LOAD (1 cycle): load_A=1, load_B=1, counter<=0. Then go to CHECK.
  - CHECK (1 cycle): no strobes. If Q_LSB=1 go to ADD, else go to SHIFT.
  - ADD (1 cycle): load_add=1, add_sub=0 (add). Then go to SHIFT.
  - SHIFT (1 cycle): shift_HQ_LQ=1. If counter==N-1, go to DONE; else counter<=counter+1 and go to CHECK.
  - DONE (1 cycle): done=1, result_valid<=1. Then go to IDLE.
- Counter: $clog2(N) bits. It never wraps; the exit compare is at N-1.
- Latency, LOAD to DONE inclusive: 2 + 2N + k cycles, where k is the number of 1s in B. For N=8 this is 18 (B=0) to 26 (B=0xFF). done rises 1 cycle after the accepted edge plus 1+2N+k cycles.
- No two strobes among load_A/B, load_add and shift_HQ_LQ are ever active in the same cycle. add_sub=0 whenever load_add=0.
- Unknown or illegal state encoding returns to IDLE with all strobes 0.

Decomposition:
- Shared package mult_pkg:
  - typedef struct packed mult_control_t {load_A, load_B, load_add, shift_HQ_LQ, add_sub}, shared with the multiplier datapath and the top.
  - typedef enum logic [2:0] mult_state_t {IDLE, LOAD, CHECK, ADD, SHIFT, DONE}.
  - localparam MULT_N_DEFAULT = 8.
- Sub-module edge_detect_rise (clk, rst, in, pulse): one register plus a gate, reused for start. All other logic stays in one FSM module.

Test Plan:
- Reset mid-operation: assert rst during the ADD of a running multiply. Required: same-cycle all strobes 0, busy=0, result_valid=0. After release, state is IDLE and no activity occurs until a new start edge.
- B=0x00 (Q_LSB always 0): start pulse. Required: LOAD, then 8x(CHECK, SHIFT), then DONE. That is 18 busy cycles, zero load_add pulses, 8 shift pulses, and one done pulse.
- B=0x05 (bench models Q shifting right; Q_LSB sequence 1,0,1,0,0,0,0,0): required 20 busy cycles, load_add exactly at iterations 0 and 2, and 8 shifts.
- B=0xFF: required 26 busy cycles with 8 load_add and 8 shift pulses strictly alternating.
- End-to-end with behavioural datapath: A=12, B=10 gives Y=120 when done=1; A=255, B=255 gives Y=65025.
- Start held high for 40 cycles: exactly one multiplication. A second rising edge while busy is ignored. A rising edge after DONE starts a new run and clears result_valid in the LOAD cycle.
